// File: rtl/aes_pkg.sv
// Shared types, FSM encoding and GF(2^8) helper for the AES MixColumns datapath.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam logic MC_FWD = 1'b0;
    localparam logic MC_INV = 1'b1;

    // Multiply by x modulo the AES polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_col_core.sv
// One-column MixColumns / InvMixColumns, purely combinational, built from xtime chains.
module mix_col_core
    import aes_pkg::*;
(
    input  col_t col_in,
    input  logic inv,
    output col_t col_out
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] b  [4];

    // NOTE: combinational logic uses blocking assignments and writes every
    // variable on every pass, so no latch can be inferred.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r]  = col_in[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            if (inv == MC_INV) begin
                // 0E, 0B, 0D, 09 expressed as sums of a, 2a, 4a, 8a
                b[r] = (x8[r] ^ x4[r] ^ x2[r])
                     ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                     ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                     ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            end else begin
                b[r] = x2[r]
                     ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                     ^ a[(r+2)%4]
                     ^ a[(r+3)%4];
            end
        end
        col_out = {b[0], b[1], b[2], b[3]};
    end

endmodule

// File: rtl/mix_col_engine.sv
// Handshaked MixColumns / InvMixColumns over the full AES state,
// transforming COLS_PER_CYCLE columns per clock.
module mix_col_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   clear,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t data_in,
    input  logic   inv,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t data_out
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
            $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    mc_state_t   state;
    col_t [3:0]  src;
    col_t [3:0]  result;
    logic [1:0]  col_cnt;
    logic        inv_q;
    logic [1:0]  col_idx  [COLS_PER_CYCLE];
    col_t        core_out [COLS_PER_CYCLE];

    // Column c sits in packed slot 3-c, i.e. ~c for a 2-bit index.
    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_core
        assign col_idx[i] = col_cnt + 2'(i);

        mix_col_core u_core (
            .col_in  (src[~col_idx[i]]),
            .inv     (inv_q),
            .col_out (core_out[i])
        );
    end

    // NOTE: src is always loaded at acceptance before it is read, so it has
    // no reset and lives in its own reset-free block.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid && !clear) begin
            src <= data_in;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            result  <= '0;
            col_cnt <= 2'd0;
            inv_q   <= MC_FWD;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        inv_q   <= inv;
                        col_cnt <= 2'd0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        result[~col_idx[i]] <= core_out[i];
                    end
                    col_cnt <= col_cnt + STEP;
                    if (col_cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign data_out  = result;

endmodule

// File: tb/tb_mix_col_engine.sv
// Self-checking bench: three engine instances (1, 2 and 4 columns per cycle)
// compared against a polynomial-arithmetic MixColumns reference model.
module tb_mix_col_engine;

    typedef logic [127:0] state_t;

    localparam state_t FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam state_t FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

    typedef struct {
        int     k;
        logic   mode;
        state_t din;
        state_t exp;
        int     lat;
    } vec_t;

    logic   clk = 1'b0;
    logic   n_rst;
    logic   clear     [3];
    logic   in_valid  [3];
    logic   in_ready  [3];
    logic   inv       [3];
    logic   out_valid [3];
    logic   out_ready [3];
    state_t data_in   [3];
    state_t data_out  [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_col_engine #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .clear     (clear[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in[g]),
            .inv       (inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Carry-less product followed by long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
        return p[7:0];
    endfunction

    function automatic state_t model(input state_t s, input logic mode);
        logic [7:0] coef [4];
        logic [7:0] acc;
        state_t     r;
        if (mode) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(coef[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Drives one transaction at posedge+1; returns the result and the number of
    // edges from acceptance to out_valid. With out_ready high it also waits for
    // the return to IDLE.
    task automatic transact(input int k, input logic mode, input state_t d, input bit disturb,
                            output state_t res, output int lat);
        check($sformatf("in_ready before accept k%0d", k), in_ready[k], 1'b1);
        in_valid[k] = 1'b1;
        data_in[k]  = d;
        inv[k]      = mode;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        res = 'x;
        forever begin
            if (disturb) begin
                inv[k]     = ~inv[k];
                data_in[k] = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            lat++;
            if (out_valid[k]) break;
            if (lat >= 20) begin
                total++;
                $display("FAIL timeout k%0d: out_valid still %b after %0d cycles", k, out_valid[k], lat);
                return;
            end
        end
        res = data_out[k];
        if (out_ready[k]) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t   vecs [$];
        state_t res;
        state_t d;
        logic   m;
        int     lat;
        bit     seen;

        for (int k = 0; k < 3; k++) begin
            clear[k] = 1'b0; in_valid[k] = 1'b0; inv[k] = 1'b0;
            out_ready[k] = 1'b1; data_in[k] = '0;
        end
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset in_ready k%0d", k),  in_ready[k],  1'b1);
            check($sformatf("reset out_valid k%0d", k), out_valid[k], 1'b0);
            check($sformatf("reset data_out k%0d", k),  data_out[k],  '0);
        end
        #19 n_rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors; inverse entries also toggle inv/data_in while busy.
        vecs.push_back('{0, 1'b0, {32'hdb135345, 96'h0}, {32'h8e4da1bc, 96'h0}, 4});
        for (int k = 0; k < 3; k++) begin
            vecs.push_back('{k, 1'b0, FIPS_IN,  FIPS_OUT, 4 >> k});
            vecs.push_back('{k, 1'b1, FIPS_OUT, FIPS_IN,  4 >> k});
        end
        foreach (vecs[i]) begin
            transact(vecs[i].k, vecs[i].mode, vecs[i].din, vecs[i].mode, res, lat);
            check($sformatf("vec%0d data", i),    res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
        end

        // Random states and modes against the reference model.
        for (int n = 0; n < 24; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            transact(n % 3, m, d, 1'b0, res, lat);
            check($sformatf("rand%0d k%0d inv%0d", n, n % 3, m), res, model(d, m));
            check($sformatf("rand%0d latency", n), lat, 4 >> (n % 3));
        end

        // Backpressure: result held for 10 cycles, input pulses ignored.
        out_ready[0] = 1'b0;
        transact(0, 1'b0, FIPS_IN, 1'b0, res, lat);
        check("bp first result", res, FIPS_OUT);
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = (c % 2 == 0);
            data_in[0]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check($sformatf("bp c%0d out_valid", c), out_valid[0], 1'b1);
            check($sformatf("bp c%0d in_ready", c),  in_ready[0],  1'b0);
            check($sformatf("bp c%0d data_out", c),  data_out[0],  FIPS_OUT);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp release in_ready",  in_ready[0],  1'b1);
        check("bp release out_valid", out_valid[0], 1'b0);

        // Abort in the second BUSY cycle.
        in_valid[0] = 1'b1; data_in[0] = FIPS_IN; inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        seen = out_valid[0];
        @(posedge clk); #1;
        seen |= out_valid[0];
        clear[0] = 1'b1;
        @(posedge clk); #1;
        clear[0] = 1'b0;
        check("abort in_ready",  in_ready[0],  1'b1);
        check("abort out_valid", out_valid[0], 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen |= out_valid[0];
        end
        check("abort out_valid never rose", seen, 1'b0);
        transact(0, 1'b1, FIPS_OUT, 1'b0, res, lat);
        check("after abort data", res, FIPS_IN);
        check("after abort latency", lat, 4);

        // Asynchronous reset between clock edges mid-BUSY.
        in_valid[0] = 1'b1; data_in[0] = FIPS_IN; inv[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #3;
        n_rst = 1'b0;
        #1;
        check("async rst out_valid", out_valid[0], 1'b0);
        check("async rst in_ready",  in_ready[0],  1'b1);
        check("async rst data_out",  data_out[0],  '0);
        #2 n_rst = 1'b1;
        @(posedge clk); #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        transact(0, 1'b0, d, 1'b0, res, lat);
        check("after rst data", res, model(d, 1'b0));
        check("after rst latency", lat, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
